id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of rs1_data, rs2_data, imm and pc payload fields.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, width of the rs1, rs2 and rd address fields.
REQ-003 Parameter ALU_OP_WIDTH, default 4, width of the alu_op field.
REQ-004 Parameter CTRL_WIDTH, default 4, width of the ctrl field; ctrl all-zero means no memory or register-file side effect.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 flush_i  input  1  synchronous kill of all held entries.
REQ-008 in_valid_i  input  1  decode stage presents a packet.
REQ-009 in_ready_o  output  1  block accepts a packet this cycle.
REQ-010 in_pkt_i  input  PKT_W  packed id_ex_pkt_t: rs1_data, rs2_data, imm, pc, rs1, rs2, rd, alu_op, alu_src, ctrl.
REQ-011 out_valid_o  output  1  execute-side packet valid.
REQ-012 out_ready_i  input  1  execute stage consumes the packet this cycle.
REQ-013 out_pkt_o  output  PKT_W  registered packet to execute.
REQ-014 occupancy_o  output  2  held entries: 0, 1 or 2.

Function
REQ-015 The block SHALL transfer on an input edge when in_valid_i && in_ready_o, and on an output edge when out_valid_o && out_ready_i.
REQ-016 Latency SHALL be exactly one cycle: a packet accepted at edge N is on out_pkt_o with out_valid_o high after edge N when the main register is free.
REQ-017 out_pkt_o SHALL remain bit-stable while out_valid_o && !out_ready_i.
REQ-018 Payload registers SHALL load only on an accepted transfer; in_pkt_i is ignored when in_valid_i is low.
REQ-019 When out_valid_o is low, out_pkt_o SHALL be all-zero (bubble).
REQ-020 Order SHALL be strictly FIFO; no packet is dropped or duplicated except by flush_i.
REQ-021 Simultaneous accept and drain on a full main register SHALL replace the output packet in the same edge with no bubble.
REQ-022 flush_i high at edge N SHALL clear all entries, set occupancy_o to 0, zero out_pkt_o, and discard any packet accepted at that edge (flush dominates accept).
REQ-023 A flush with no entries held SHALL be a no-op apart from discarding the concurrent input.

Reset
REQ-024 On rst_n low, immediately and independent of clk: out_valid_o=0, out_pkt_o=0, occupancy_o=0, skid entry cleared, state EMPTY.
REQ-025 in_ready_o SHALL be 1 from reset deassertion onward when no entry is held.
REQ-026 Reset asserted mid-transfer SHALL lose all in-flight packets, with no partial update.

Configuration
REQ-027 Macro ID_EX_SKID_EN SHALL select the ready path.
REQ-028 Without ID_EX_SKID_EN: single entry; in_ready_o = !out_valid_o || out_ready_i (combinational); occupancy_o never exceeds 1.
REQ-029 With ID_EX_SKID_EN: two entries (main + skid); in_ready_o is registered and equals "skid empty"; FSM states EMPTY, ONE, TWO.
REQ-030 FSM transitions: EMPTY->ONE on accept; ONE->TWO on accept while the output is stalled; ONE->EMPTY on drain without accept; TWO->ONE on drain, skid moved to main; flush_i forces EMPTY from any state.
REQ-031 In state TWO, in_ready_o SHALL be 0.

Structure
REQ-032 Shared package id_ex_pkg SHALL hold id_ex_pkt_t, PKT_W and the bubble constant ID_EX_BUBBLE (all-zero).
REQ-033 The skid storage plus FSM SHALL be one sub-module, id_ex_skid, instantiated only under ID_EX_SKID_EN.

Verification
REQ-034 Reset: release rst_n with in_valid_i=0 -> out_valid_o=0, out_pkt_o=0, occupancy_o=0, in_ready_o=1.
REQ-035 Stream: 8 packets, pc=0x100..0x11C, out_ready_i=1 -> same order, each one cycle after acceptance, no gaps.
REQ-036 Backpressure (SKID_EN): out_ready_i=0 while pc 0x200 and 0x204 are sent -> occupancy_o=2, in_ready_o=0, out_pkt_o.pc held at 0x200; release -> 0x200 then 0x204.
REQ-037 Flush: occupancy 2, flush_i=1 with in_valid_i=1 (pc 0x300) -> next cycle out_valid_o=0, occupancy_o=0, and 0x300 never appears.
REQ-038 Full-rate replace: single-entry build, out_ready_i=1 with in_valid_i=1 every cycle -> in_ready_o stays 1, with one packet out per cycle.
REQ-039 Async reset: assert rst_n mid-cycle at occupancy 2 -> outputs clear before the next clk edge.

Source files
------------

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: decode-to-execute packet layout and shared constants.
// Field widths here match the default parameters of id_ex_pipe.
package id_ex_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_ALU_OP_WIDTH   = 4;
    localparam int DEF_CTRL_WIDTH     = 4;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]     rs1_data;
        logic [DEF_DATA_WIDTH-1:0]     rs2_data;
        logic [DEF_DATA_WIDTH-1:0]     imm;
        logic [DEF_DATA_WIDTH-1:0]     pc;
        logic [DEF_REG_ADDR_WIDTH-1:0] rs1;
        logic [DEF_REG_ADDR_WIDTH-1:0] rs2;
        logic [DEF_REG_ADDR_WIDTH-1:0] rd;
        logic [DEF_ALU_OP_WIDTH-1:0]   alu_op;
        logic                          alu_src;
        logic [DEF_CTRL_WIDTH-1:0]     ctrl;
    } id_ex_pkt_t;

    localparam int PKT_W = $bits(id_ex_pkt_t);

    // ctrl == 0 in the bubble means no memory or register-file side effect
    localparam logic [PKT_W-1:0] ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_skid.sv
// id_ex_skid: main + skid register pair with EMPTY/ONE/TWO control FSM.
// in_ready_o is registered and is high exactly when the skid entry is free.
module id_ex_skid #(
    parameter int PKT_W = 152
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PKT_W-1:0] in_pkt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PKT_W-1:0] out_pkt_o,
    output logic [1:0]       occupancy_o
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic             r_rdy;
    logic [PKT_W-1:0] r_main;
    logic [PKT_W-1:0] r_skid;
    logic             w_acc;
    logic             w_drn;

    assign w_acc = in_valid_i && r_rdy;
    assign w_drn = (r_state != S_EMPTY) && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_rdy   <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush_i) begin
            r_state <= S_EMPTY;
            r_rdy   <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_main  <= in_pkt_i;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_acc && !w_drn) begin
                        r_skid  <= in_pkt_i;
                        r_state <= S_TWO;
                        r_rdy   <= 1'b0;
                    end else if (w_acc) begin
                        r_main <= in_pkt_i;
                    end else if (w_drn) begin
                        r_main  <= '0;
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // ready is low here, so only a drain can happen
                    if (w_drn) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_state <= S_ONE;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_rdy   <= 1'b1;
                    r_main  <= '0;
                    r_skid  <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = r_rdy;
    assign out_valid_o = (r_state != S_EMPTY);
    assign out_pkt_o   = r_main;
    assign occupancy_o = r_state;

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode-to-execute pipeline register with valid/ready handshake.
// Define ID_EX_SKID_EN for a two-entry skid buffer with registered in_ready_o.
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int ALU_OP_WIDTH   = DEF_ALU_OP_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH,
    localparam int L_PKT_W = 4 * DATA_WIDTH + 3 * REG_ADDR_WIDTH
                           + ALU_OP_WIDTH + 1 + CTRL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [L_PKT_W-1:0] in_pkt_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [L_PKT_W-1:0] out_pkt_o,
    output logic [1:0]         occupancy_o
);

`ifdef ID_EX_SKID_EN

    id_ex_skid #(
        .PKT_W (L_PKT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_pkt_i    (in_pkt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pkt_o   (out_pkt_o),
        .occupancy_o (occupancy_o)
    );

`else

    logic               r_valid;
    logic [L_PKT_W-1:0] r_pkt;
    logic               w_acc;

    assign in_ready_o = !r_valid || out_ready_i;
    assign w_acc      = in_valid_i && in_ready_o;

    // payload is zeroed whenever the entry empties so a bubble reads as 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_pkt   <= in_pkt_i;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end
    end

    assign out_valid_o = r_valid;
    assign out_pkt_o   = r_pkt;
    assign occupancy_o = {1'b0, r_valid};

`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed + random scoreboard bench for id_ex_pipe.
// Expectations adapt to ID_EX_SKID_EN when the macro is defined.
module tb_id_ex_pipe;
    import id_ex_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    id_ex_pkt_t       in_pkt;
    logic [PKT_W-1:0] in_pkt_i;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [PKT_W-1:0] out_pkt_o;
    logic [1:0]       occupancy_o;

    id_ex_pkt_t q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    bit         last_acc;
    bit         got;
    id_ex_pkt_t o;

    assign in_pkt_i = in_pkt;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_pkt_i    (in_pkt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pkt_o   (out_pkt_o),
        .occupancy_o (occupancy_o)
    );

    task automatic chk(input string tag,
                       input logic [PKT_W-1:0] obs,
                       input logic [PKT_W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_rdy();
`ifdef ID_EX_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready_i;
`endif
    endfunction

    function automatic id_ex_pkt_t mk(input logic [31:0] pc);
        id_ex_pkt_t p;
        p = PKT_W'({$urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom()});
        p.pc = pc;
        return p;
    endfunction

    // check outputs mid-cycle, update the model, then advance one edge
    task automatic tick();
        bit rdy;
        #2;
        rdy = exp_rdy();
        chk("occupancy", occupancy_o, q.size());
        chk("out_valid", out_valid_o, q.size() != 0);
        chk("in_ready", in_ready_o, rdy);
        if (q.size() == 0) chk("bubble", out_pkt_o, ID_EX_BUBBLE);
        else chk("out_pkt", out_pkt_o, q[0]);
        last_acc = in_valid_i && rdy && !flush_i;
        if (q.size() != 0 && out_ready_i) void'(q.pop_front());
        if (flush_i) q.delete();
        else if (last_acc) q.push_back(in_pkt);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input id_ex_pkt_t p);
        int n;
        in_valid_i = 1'b1;
        in_pkt = p;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 20) begin
            tick();
            n++;
        end
        if (!last_acc) chk("send_timeout", 1'b0, 1'b1);
        in_valid_i = 1'b0;
    endtask

    initial begin
        in_pkt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            in_pkt = mk(32'h100 + 32'(4 * i));
            tick();
            chk("stream_acc", last_acc, 1'b1);
        end
        in_valid_i = 1'b0;
        repeat (2) tick();

        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        in_pkt = mk(32'h200);
        tick();
        in_pkt = mk(32'h204);
        tick();
        got = last_acc;
        in_valid_i = !got;
        tick();
        got = got || last_acc;
        o = out_pkt_o;
        chk("held_pc", o.pc, 32'h200);
`ifdef ID_EX_SKID_EN
        chk("bp_occ", occupancy_o, 2'd2);
        chk("bp_rdy", in_ready_o, 1'b0);
`endif
        out_ready_i = 1'b1;
        if (!got) send(in_pkt);
        in_valid_i = 1'b0;
        repeat (3) tick();

        out_ready_i = 1'b0;
        send(mk(32'h280));
        in_valid_i = 1'b1;
        in_pkt = mk(32'h284);
        tick();
        flush_i = 1'b1;
        in_pkt = mk(32'h300);
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_occ", occupancy_o, 2'd0);
        chk("flush_valid", out_valid_o, 1'b0);
        out_ready_i = 1'b1;
        repeat (3) tick();

        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1'b1;
            in_pkt = mk(32'h400 + 32'(4 * i));
            tick();
            chk("fullrate_rdy", in_ready_o, 1'b1);
        end
        in_valid_i = 1'b0;
        tick();

        for (int i = 0; i < 300; i++) begin
            in_valid_i = 1'($urandom_range(1, 0));
            out_ready_i = 1'($urandom_range(1, 0));
            flush_i = ($urandom_range(31, 0) == 0);
            in_pkt = mk(32'h1000 + 32'(4 * i));
            tick();
        end
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) tick();

        out_ready_i = 1'b0;
        send(mk(32'h500));
        in_valid_i = 1'b1;
        in_pkt = mk(32'h504);
        tick();
        in_valid_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_occ", occupancy_o, 2'd0);
        chk("arst_valid", out_valid_o, 1'b0);
        chk("arst_pkt", out_pkt_o, ID_EX_BUBBLE);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        out_ready_i = 1'b1;
        send(mk(32'h600));
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
